song_seq_ctrl: RTL and testbench

//   Sequencer for the music player. Walks a note ROM at the beat rate and drives
//   the {high,med,low} note digits and a tone-enable to the tone generator/speaker.

---
 rtl/song_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_song_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/song_seq_ctrl.sv
// song_seq_ctrl: beat-rate note ROM sequencer driving tone digits and tone enable.
// Optional SONG_LOOP_EN: replay the song from note 0 instead of stopping at the end.
module song_seq_ctrl #(
  parameter int BEAT_DIV = 1500000,
  parameter int IDX_W    = 6,
  parameter int SEL_W    = 2
) (
  input  logic                   clk_6MHz,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   stop,
  input  logic [SEL_W-1:0]       song_sel,
  output logic [SEL_W+IDX_W-1:0] rom_addr,
  input  logic [11:0]            rom_data,
  output logic [3:0]             high,
  output logic [3:0]             med,
  output logic [3:0]             low,
  output logic                   tone_en,
  output logic                   beat,
  output logic                   playing,
  output logic                   song_done
);
  localparam int CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, PAUSE, DONE} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] note_idx, idx_n;
  logic [CNT_W-1:0] beat_cnt, cnt_n;
  logic [SEL_W-1:0] song_sel_q, sel_n;
  logic [11:0]      digits, digits_n;
  logic             tone_n, beat_n, done_n;

  assign rom_addr        = {song_sel_q, note_idx};
  assign {high, med, low} = digits;
  assign playing         = (state == FETCH) || (state == LOAD) || (state == PLAY);

  always_comb begin
    state_n  = state;
    idx_n    = note_idx;
    cnt_n    = beat_cnt;
    sel_n    = song_sel_q;
    digits_n = digits;
    tone_n   = tone_en;
    beat_n   = 1'b0;
    done_n   = 1'b0;
    if (stop) begin
      state_n  = IDLE;
      idx_n    = '0;
      cnt_n    = '0;
      digits_n = '0;
      tone_n   = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state_n = FETCH;
          sel_n   = song_sel;
          idx_n   = '0;
        end
        FETCH: state_n = LOAD;
        LOAD: begin
          cnt_n = '0;
          if (rom_data == 12'hFFF) begin
            done_n = 1'b1;
            tone_n = 1'b0;
`ifdef SONG_LOOP_EN
            state_n = FETCH;
            idx_n   = '0;
`else
            state_n = DONE;
`endif
          end else begin
            digits_n = rom_data;
            tone_n   = |rom_data;
            state_n  = PLAY;
          end
        end
        // pause wins over the beat so a paused note resumes with its count intact
        PLAY: if (pause) begin
          state_n = PAUSE;
          tone_n  = 1'b0;
        end else if (beat_cnt == CNT_LAST) begin
          beat_n = 1'b1;
          cnt_n  = '0;
          if (note_idx == IDX_LAST) begin
            done_n = 1'b1;
            tone_n = 1'b0;
`ifdef SONG_LOOP_EN
            state_n = FETCH;
            idx_n   = '0;
`else
            state_n = DONE;
`endif
          end else begin
            idx_n   = note_idx + 1'b1;
            state_n = FETCH;
          end
        end else begin
          cnt_n = beat_cnt + 1'b1;
        end
        PAUSE: if (start || pause) begin
          state_n = PLAY;
          tone_n  = |digits;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_6MHz) begin
    if (!rst) begin
      state      <= IDLE;
      note_idx   <= '0;
      beat_cnt   <= '0;
      song_sel_q <= '0;
      digits     <= '0;
      tone_en    <= 1'b0;
      beat       <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      state      <= state_n;
      note_idx   <= idx_n;
      beat_cnt   <= cnt_n;
      song_sel_q <= sel_n;
      digits     <= digits_n;
      tone_en    <= tone_n;
      beat       <= beat_n;
      song_done  <= done_n;
    end
  end
endmodule

// File: tb/tb_song_seq_ctrl.sv
// tb_song_seq_ctrl: directed and random checks of song_seq_ctrl against a note-schedule model.
module tb_song_seq_ctrl;
  localparam int BD = 10;
  logic clk = 0, rst = 0, start = 0, pause = 0, stop = 0;
  logic [1:0] song_sel = 0;
  logic [7:0] rom_addr;
  logic [11:0] rom_data = 0;
  logic [3:0] high, med, low;
  logic tone_en, beat, playing, song_done;
  logic [11:0] rom [0:255];
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  song_seq_ctrl #(.BEAT_DIV(BD), .IDX_W(6), .SEL_W(2)) dut (
    .clk_6MHz(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .song_sel(song_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .high(high), .med(med), .low(low), .tone_en(tone_en), .beat(beat),
    .playing(playing), .song_done(song_done));

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Model: a running song is a chain of note slots of BD+2 cycles
  // (phase 0 fetch, phase 1 load, phases 2..BD+1 sounding).
  int mode = 0; // 0 idle, 1 running, 2 finished
  bit m_pause = 0, m_tone = 0, m_beat = 0, m_done = 0;
  int phase = 0;
  logic [1:0] m_sel = 0;
  logic [5:0] m_idx = 0;
  logic [11:0] m_dig = 0;

  task automatic end_song();
    m_done = 1;
    m_tone = 0;
`ifdef SONG_LOOP_EN
    m_idx = 0;
    phase = 0;
`else
    mode = 2;
`endif
  endtask

  always @(posedge clk) begin
    m_beat = 0;
    m_done = 0;
    if (!rst) begin
      mode = 0; m_pause = 0; phase = 0; m_sel = 0; m_idx = 0; m_dig = 0; m_tone = 0;
    end else if (stop) begin
      mode = 0; m_pause = 0; m_idx = 0; m_dig = 0; m_tone = 0;
    end else if (mode != 1) begin
      if (start) begin
        mode = 1; m_pause = 0; m_sel = song_sel; m_idx = 0; phase = 0;
      end
    end else if (m_pause) begin
      if (start || pause) begin
        m_pause = 0;
        m_tone = (m_dig != 0);
      end
    end else if (phase == 0) begin
      phase = 1;
    end else if (phase == 1) begin
      if (rom[{m_sel, m_idx}] == 12'hFFF) end_song();
      else begin
        m_dig = rom[{m_sel, m_idx}];
        m_tone = (m_dig != 0);
        phase = 2;
      end
    end else if (pause) begin
      m_pause = 1;
      m_tone = 0;
    end else if (phase == BD + 1) begin
      m_beat = 1;
      if (m_idx == 6'd63) end_song();
      else begin
        m_idx = m_idx + 6'd1;
        phase = 0;
      end
    end else begin
      phase = phase + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  wire [23:0] dut_vec = {rom_addr, high, med, low, tone_en, beat, playing, song_done};

  always @(negedge clk)
    if (chk_en)
      chk("cycle", {8'd0, dut_vec},
          {8'd0, m_sel, m_idx, m_dig, m_tone, m_beat, (mode == 1) && !m_pause, m_done});

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_stop();
    stop = 1;
    cyc(1);
    stop = 0;
    cyc(2);
  endtask

  task automatic go(input logic [1:0] s);
    song_sel = s;
    start = 1;
    cyc(1);
    start = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 12'h111;
    rom[0] = 12'h001; rom[1] = 12'h010; rom[2] = 12'hFFF;
    rom[64] = 12'h000; rom[65] = 12'h005; rom[66] = 12'hFFF;
    for (int i = 128; i < 192; i++) rom[i] = 12'($urandom_range(1, 12'hFFE));
    for (int i = 192; i < 256; i++) rom[i] = ($urandom % 6 == 0) ? 12'h000 : 12'($urandom_range(1, 12'hFFE));
    rom[192 + 40] = 12'hFFF;

    cyc(3);
    chk_en = 1;
    chk("reset", {8'd0, dut_vec}, 0);
    rst = 1;
    cyc(1);

    // song 0: two notes then marker
    go(0);
    chk("t1_playing", playing, 1);
    cyc(2);
    chk("t1_note0", {tone_en, high, med, low}, 13'h1001);
    cyc(10);
    chk("t1_beat", {beat, high, med, low}, 13'h1001);
    cyc(1);
    chk("t1_note0_last", {high, med, low}, 12'h001);
    cyc(1);
    chk("t1_note1", {tone_en, high, med, low}, 13'h1010);
    cyc(12);
    chk("t1_done", {song_done, tone_en, high, med, low}, 14'h2010);
    cyc(1);
`ifdef SONG_LOOP_EN
    chk("t1_after", {song_done, playing}, 2'b01);
`else
    chk("t1_after", {song_done, playing}, 2'b00);
`endif
    pulse_stop();

    // simultaneous start+pause+stop in PLAY
    go(0);
    cyc(5);
    start = 1; pause = 1; stop = 1;
    cyc(1);
    start = 0; pause = 0; stop = 0;
    chk("t3_all_zero", {8'd0, dut_vec}, 0);
    cyc(2);

    // pause at beat_cnt 4 for 20 cycles
    go(0);
    cyc(6);
    pause = 1;
    cyc(1);
    pause = 0;
    chk("t2_paused_first", {tone_en, playing}, 0);
    cyc(19);
    chk("t2_paused_last", tone_en, 0);
    pause = 1;
    cyc(1);
    pause = 0;
    chk("t2_resumed", tone_en, 1);
    cyc(6);
    chk("t2_beat", beat, 1);
    pulse_stop();

    // rest note
    go(1);
    cyc(2);
    chk("t4_rest", {tone_en, playing, high, med, low}, 14'h1000);
    cyc(10);
    chk("t4_beat", beat, 1);
    pulse_stop();

    // 64 notes with no marker
    go(2);
    cyc(790);
`ifdef SONG_LOOP_EN
    chk("t5_wrap", playing, 1);
`else
    chk("t5_wrap", {playing, rom_addr}, {1'b0, 8'hBF});
`endif
    pulse_stop();

    // reset mid-note
    go(3);
    cyc(30);
    rst = 0;
    cyc(1);
    chk("t6_rst", {8'd0, dut_vec}, 0);
    rst = 1;
    cyc(1);

    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 40 == 0);
      pause = ($urandom % 20 == 0);
      stop = ($urandom % 200 == 0);
      rst = ($urandom % 600 != 0);
      song_sel = 2'($urandom);
      cyc(1);
    end
    start = 0; pause = 0; stop = 0; rst = 1;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
